// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared types and sizes for the Smith-Waterman core scheduler.
//
// Contents:
//   - Default sizes taken from the SW_core build macros REF_MAX_LENGTH,
//     READ_MAX_LENGTH and DP_SW_SCORE_BITWIDTH. If a macro is not defined
//     by the build, a default is supplied here.
//   - sched_state_t : scheduler FSM state encoding
//   - sw_job_t      : one ref/read job as latched from a requester
//   - sw_result_t   : one tagged result as returned to the host side
//   - job_is_valid(): length sanity check applied before issuing to the core
//
// The struct widths follow these package sizes, so the scheduler parameters
// are expected to stay at their package-derived defaults; change the macros
// (and NUM_REQ_DEF) to resize the design.
// -----------------------------------------------------------------------------
`ifndef REF_MAX_LENGTH
`define REF_MAX_LENGTH 128
`endif
`ifndef READ_MAX_LENGTH
`define READ_MAX_LENGTH 128
`endif
`ifndef DP_SW_SCORE_BITWIDTH
`define DP_SW_SCORE_BITWIDTH 16
`endif

package sw_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int REF_MAX_LEN   = `REF_MAX_LENGTH;
    localparam int READ_MAX_LEN  = `READ_MAX_LENGTH;
    localparam int SCORE_BITS    = `DP_SW_SCORE_BITWIDTH;

    // 2 bits per base, sequences are MSB-aligned in these fields
    localparam int REF_BITS      = 2 * REF_MAX_LEN;
    localparam int READ_BITS     = 2 * READ_MAX_LEN;
    // Lengths are 1-based, so they need one bit more than an index
    localparam int REF_LEN_BITS  = $clog2(REF_MAX_LEN) + 1;
    localparam int READ_LEN_BITS = $clog2(READ_MAX_LEN) + 1;
    localparam int ROW_BITS      = $clog2(READ_MAX_LEN);
    localparam int COL_BITS      = $clog2(REF_MAX_LEN);
    localparam int ID_BITS       = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [REF_BITS-1:0]      ref_seq;
        logic [READ_BITS-1:0]     read_seq;
        logic [REF_LEN_BITS-1:0]  ref_len;
        logic [READ_LEN_BITS-1:0] read_len;
    } sw_job_t;

    typedef struct packed {
        logic [ID_BITS-1:0]           id;
        logic signed [SCORE_BITS-1:0] score;
        logic [ROW_BITS-1:0]          row;
        logic [COL_BITS-1:0]          col;
        logic                         err;
    } sw_result_t;

    // A job the core can accept: both lengths in 1..max
    function automatic logic job_is_valid(input sw_job_t j);
        return (j.ref_len  != '0) && (int'(j.ref_len)  <= REF_MAX_LEN) &&
               (j.read_len != '0) && (int'(j.read_len) <= READ_MAX_LEN);
    endfunction

endpackage

// File: rtl/sw_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sw_rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting at
// index ptr and wrapping around; the first requester found wins.
//
// Ports:
//   req        in  NUM_REQ        request vector
//   ptr        in  clog2(NUM_REQ) index with highest priority this round
//   grant      out NUM_REQ        one-hot grant (all zero when no request)
//   grant_idx  out clog2(NUM_REQ) binary index of the granted requester
//   grant_any  out 1              at least one request is present
// -----------------------------------------------------------------------------
module sw_rr_arbiter
    import sw_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
)(
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int ID_W = $clog2(NUM_REQ);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_core_scheduler.sv
// -----------------------------------------------------------------------------
// sw_core_scheduler
// Shares one SW_core Smith-Waterman datapath among NUM_REQ requesters. One job
// is in flight at a time: a round-robin grant latches a requester's job, the
// job is handed to the core over its valid/ready handshake, and the core's
// score/row/column come back tagged with the requester index.
//
// Optional feature: define SW_SCHED_WATCHDOG_EN to add a watchdog that gives
// up on the core after TIMEOUT_CYCLES cycles in ISSUE+WAIT and returns an
// error result. Without the macro there is no counter and WAIT lasts as long
// as the core takes.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid / req_ready    per-requester job present / one-hot accept pulse
//   req_ref, req_read        packed sequences per requester, MSB-aligned
//   req_ref_len, req_read_len 1-based lengths per requester
//   core_ready / core_valid  job handshake with SW_core (o_ready / i_valid)
//   core_ref .. core_read_len job data to SW_core, zero unless core_valid
//   core_res_ready / core_res_valid result handshake with SW_core
//   core_score, core_row, core_col  result from SW_core
//   res_valid / res_ready    result handshake to the host side
//   res_id, res_score, res_row, res_col, res_err  tagged result
//   jobs_done                completed-job counter (wraps)
// -----------------------------------------------------------------------------
module sw_core_scheduler
    import sw_pkg::*;
#(
    parameter int NUM_REQ         = NUM_REQ_DEF,
    parameter int REF_MAX_LENGTH  = REF_MAX_LEN,
    parameter int READ_MAX_LENGTH = READ_MAX_LEN,
    parameter int SCORE_W         = SCORE_BITS
`ifdef SW_SCHED_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES  = 65535
`endif
)(
    input  logic                                            clk,
    input  logic                                            rst,

    input  logic [NUM_REQ-1:0]                              req_valid,
    output logic [NUM_REQ-1:0]                              req_ready,
    input  logic [NUM_REQ*2*REF_MAX_LENGTH-1:0]             req_ref,
    input  logic [NUM_REQ*2*READ_MAX_LENGTH-1:0]            req_read,
    input  logic [NUM_REQ*($clog2(REF_MAX_LENGTH)+1)-1:0]   req_ref_len,
    input  logic [NUM_REQ*($clog2(READ_MAX_LENGTH)+1)-1:0]  req_read_len,

    input  logic                                            core_ready,
    output logic                                            core_valid,
    output logic [2*REF_MAX_LENGTH-1:0]                     core_ref,
    output logic [2*READ_MAX_LENGTH-1:0]                    core_read,
    output logic [$clog2(REF_MAX_LENGTH):0]                 core_ref_len,
    output logic [$clog2(READ_MAX_LENGTH):0]                core_read_len,
    output logic                                            core_res_ready,
    input  logic                                            core_res_valid,
    input  logic signed [SCORE_W-1:0]                       core_score,
    input  logic [$clog2(READ_MAX_LENGTH)-1:0]              core_row,
    input  logic [$clog2(REF_MAX_LENGTH)-1:0]               core_col,

    output logic                                            res_valid,
    input  logic                                            res_ready,
    output logic [$clog2(NUM_REQ)-1:0]                      res_id,
    output logic signed [SCORE_W-1:0]                       res_score,
    output logic [$clog2(READ_MAX_LENGTH)-1:0]              res_row,
    output logic [$clog2(REF_MAX_LENGTH)-1:0]               res_col,
    output logic                                            res_err,
    output logic [15:0]                                     jobs_done
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int REF_W  = 2 * REF_MAX_LENGTH;
    localparam int READ_W = 2 * READ_MAX_LENGTH;
    localparam int RLEN_W = $clog2(REF_MAX_LENGTH) + 1;
    localparam int DLEN_W = $clog2(READ_MAX_LENGTH) + 1;

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cur_id;
    sw_job_t          job;
    sw_job_t          sel_job;
    sw_result_t       res_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               wd_expired;

    sw_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Job fields of the requester the arbiter currently points at
    always_comb begin
        sel_job.ref_seq  = req_ref[grant_idx*REF_W +: REF_W];
        sel_job.read_seq = req_read[grant_idx*READ_W +: READ_W];
        sel_job.ref_len  = req_ref_len[grant_idx*RLEN_W +: RLEN_W];
        sel_job.read_len = req_read_len[grant_idx*DLEN_W +: DLEN_W];
    end

    // Job payload is pure data: captured on grant, never reset
    always_ff @(posedge clk) begin
        if (state == S_IDLE && grant_any) begin
            job <= sel_job;
        end
    end

`ifdef SW_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES));

    // Counts cycles spent in ISSUE+WAIT; cleared whenever a job is not there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE || state == S_WAIT) begin
            if (!wd_expired) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            cur_id         <= '0;
            req_ready      <= '0;
            core_valid     <= 1'b0;
            core_ref       <= '0;
            core_read      <= '0;
            core_ref_len   <= '0;
            core_read_len  <= '0;
            core_res_ready <= 1'b0;
            res_valid      <= 1'b0;
            res_q          <= '0;
            jobs_done      <= '0;
        end else begin
            // Single-cycle pulses and core job data default to zero
            req_ready     <= '0;
            core_valid    <= 1'b0;
            core_ref      <= '0;
            core_read     <= '0;
            core_ref_len  <= '0;
            core_read_len <= '0;

            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        req_ready <= grant;
                        cur_id    <= grant_idx;
                        rr_ptr    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                       : grant_idx + 1'b1;
                        // A malformed job skips the core; RESP builds the error result
                        state     <= job_is_valid(sel_job) ? S_ISSUE : S_RESP;
                    end
                end

                S_ISSUE: begin
                    if (wd_expired) begin
                        state <= S_RESP;
                    end else if (core_ready) begin
                        core_valid     <= 1'b1;
                        core_ref       <= job.ref_seq;
                        core_read      <= job.read_seq;
                        core_ref_len   <= job.ref_len;
                        core_read_len  <= job.read_len;
                        core_res_ready <= 1'b1;
                        state          <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (core_res_valid) begin
                        core_res_ready <= 1'b0;
                        res_valid      <= 1'b1;
                        res_q.id       <= cur_id;
                        res_q.score    <= core_score;
                        res_q.row      <= core_row;
                        res_q.col      <= core_col;
                        res_q.err      <= 1'b0;
                        state          <= S_RESP;
                    end else if (wd_expired) begin
                        core_res_ready <= 1'b0;
                        state          <= S_RESP;
                    end
                end

                S_RESP: begin
                    // Entering RESP without a result (bad job or timeout):
                    // present an error result first, then wait for the host
                    if (!res_valid) begin
                        res_valid   <= 1'b1;
                        res_q.id    <= cur_id;
                        res_q.score <= '0;
                        res_q.row   <= '0;
                        res_q.col   <= '0;
                        res_q.err   <= 1'b1;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        jobs_done <= jobs_done + 16'd1;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign res_id    = res_q.id;
    assign res_score = res_q.score;
    assign res_row   = res_q.row;
    assign res_col   = res_q.col;
    assign res_err   = res_q.err;

endmodule

// File: tb/tb_sw_core_scheduler.sv
module tb_sw_core_scheduler;
    import sw_pkg::*;

    localparam int N   = NUM_REQ_DEF;
    localparam int RLW = REF_LEN_BITS;
    localparam int DLW = READ_LEN_BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]               req_valid, req_ready;
    logic [N*REF_BITS-1:0]      req_ref;
    logic [N*READ_BITS-1:0]     req_read;
    logic [N*RLW-1:0]           req_ref_len;
    logic [N*DLW-1:0]           req_read_len;
    logic                       core_ready, core_valid;
    logic [REF_BITS-1:0]        core_ref;
    logic [READ_BITS-1:0]       core_read;
    logic [RLW-1:0]             core_ref_len;
    logic [DLW-1:0]             core_read_len;
    logic                       core_res_ready, core_res_valid;
    logic signed [SCORE_BITS-1:0] core_score;
    logic [ROW_BITS-1:0]        core_row;
    logic [COL_BITS-1:0]        core_col;
    logic                       res_valid, res_ready;
    logic [ID_BITS-1:0]         res_id;
    logic signed [SCORE_BITS-1:0] res_score;
    logic [ROW_BITS-1:0]        res_row;
    logic [COL_BITS-1:0]        res_col;
    logic                       res_err;
    logic [15:0]                jobs_done;

    sw_core_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_ref        (req_ref),
        .req_read       (req_read),
        .req_ref_len    (req_ref_len),
        .req_read_len   (req_read_len),
        .core_ready     (core_ready),
        .core_valid     (core_valid),
        .core_ref       (core_ref),
        .core_read      (core_read),
        .core_ref_len   (core_ref_len),
        .core_read_len  (core_read_len),
        .core_res_ready (core_res_ready),
        .core_res_valid (core_res_valid),
        .core_score     (core_score),
        .core_row       (core_row),
        .core_col       (core_col),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_id         (res_id),
        .res_score      (res_score),
        .res_row        (res_row),
        .res_col        (res_col),
        .res_err        (res_err),
        .jobs_done      (jobs_done)
    );

    typedef struct {
        int id;
        int rlen;
        int dlen;
        int score;
        int row;
        int col;
        bit err;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int exp_jobs = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [REF_BITS-1:0] ref_pat(input int i);
        logic [7:0] b;
        b = 8'(8'h3C + i * 17);
        return {(REF_BITS/8){b}};
    endfunction

    function automatic logic [READ_BITS-1:0] read_pat(input int i);
        logic [7:0] b;
        b = 8'(8'hA5 ^ (i * 29));
        return {(READ_BITS/8){b}};
    endfunction

    task automatic set_lens(input int id, input int rl, input int dl);
        req_ref_len[id*RLW +: RLW]  = RLW'(rl);
        req_read_len[id*DLW +: DLW] = DLW'(dl);
    endtask

    // Steps to the next negedge and waits (bounded) for an accept pulse
    task automatic wait_grant(output bit ok);
        int k;
        k = 0;
        @(negedge clk);
        while (req_ready == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        ok = (req_ready != '0);
        if (!ok) check("grant_timeout", 256'(req_ready), 256'(1));
    endtask

    // Runs a granted job to completion; called in the cycle after the grant
    task automatic complete(input vec_t v, input int hold, output int lat);
        int k;
        bit stable;
        logic [15:0] exp_s;
        logic [ROW_BITS-1:0] exp_r;
        logic [COL_BITS-1:0] exp_c;
        lat   = -1;
        exp_s = v.err ? 16'd0 : 16'(v.score);
        exp_r = v.err ? '0 : ROW_BITS'(v.row);
        exp_c = v.err ? '0 : COL_BITS'(v.col);
        if (v.err) begin
            check("err_no_core_valid", 256'(core_valid), 256'(0));
            check("err_res_early", 256'(res_valid), 256'(0));
            @(negedge clk);
            check("err_res_valid", 256'(res_valid), 256'(1));
            check("err_no_core_valid2", 256'(core_valid), 256'(0));
        end else begin
            check("core_ref_zero_idle", 256'(core_ref), 256'(0));
            k = 0;
            while (!core_valid && k < 40) begin
                @(negedge clk);
                k++;
            end
            lat = k;
            if (!core_valid) begin
                check("core_valid_timeout", 256'(core_valid), 256'(1));
                return;
            end
            check("core_ref", 256'(core_ref), 256'(ref_pat(v.id)));
            check("core_read", 256'(core_read), 256'(read_pat(v.id)));
            check("core_ref_len", 256'(core_ref_len), 256'(v.rlen));
            check("core_read_len", 256'(core_read_len), 256'(v.dlen));
            check("core_res_ready", 256'(core_res_ready), 256'(1));
            core_res_valid = 1'b1;
            core_score     = SCORE_BITS'(v.score);
            core_row       = ROW_BITS'(v.row);
            core_col       = COL_BITS'(v.col);
            @(negedge clk);
            core_res_valid = 1'b0;
            core_score     = '0;
            core_row       = '0;
            core_col       = '0;
            check("core_valid_single", 256'(core_valid), 256'(0));
            check("core_data_zero", 256'(core_read), 256'(0));
            check("res_valid", 256'(res_valid), 256'(1));
        end
        stable = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_id !== ID_BITS'(v.id) || {res_score} !== exp_s ||
                res_err !== v.err || req_ready !== '0)
                stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", 256'(stable), 256'(1));
        check("res_id", 256'(res_id), 256'(v.id));
        check("res_err", 256'(res_err), 256'(v.err));
        check("res_score", 256'({res_score}), 256'(exp_s));
        check("res_row", 256'(res_row), 256'(exp_r));
        check("res_col", 256'(res_col), 256'(exp_c));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_jobs++;
        check("jobs_done", 256'(jobs_done), 256'(16'(exp_jobs)));
        check("res_valid_drop", 256'(res_valid), 256'(0));
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int lat;
        set_lens(v.id, v.rlen, v.dlen);
        req_valid       = '0;
        req_valid[v.id] = 1'b1;
        wait_grant(ok);
        req_valid = '0;
        if (!ok) return;
        check("grant_onehot", 256'(req_ready), 256'(1 << v.id));
        complete(v, 0, lat);
        if (!v.err) check("issue_latency", 256'(lat), 256'(1));
    endtask

    vec_t vecs[7];

    initial begin
        bit ok;
        int lat;
        bit quiet;
        vec_t v;

        vecs[0] = '{id: 2, rlen: 128, dlen: 128, score: 77,     row: 5,   col: 9,   err: 1'b0};
        vecs[1] = '{id: 1, rlen: 10,  dlen: 0,   score: 0,      row: 0,   col: 0,   err: 1'b1};
        vecs[2] = '{id: 0, rlen: 0,   dlen: 5,   score: 0,      row: 0,   col: 0,   err: 1'b1};
        vecs[3] = '{id: 3, rlen: 129, dlen: 4,   score: 0,      row: 0,   col: 0,   err: 1'b1};
        vecs[4] = '{id: 3, rlen: 1,   dlen: 1,   score: -5,     row: 0,   col: 0,   err: 1'b0};
        vecs[5] = '{id: 1, rlen: 128, dlen: 129, score: 0,      row: 0,   col: 0,   err: 1'b1};
        vecs[6] = '{id: 0, rlen: 64,  dlen: 32,  score: 32767,  row: 127, col: 127, err: 1'b0};

        rst            = 1'b1;
        req_valid      = '0;
        req_ref_len    = '0;
        req_read_len   = '0;
        core_ready     = 1'b1;
        core_res_valid = 1'b0;
        core_score     = '0;
        core_row       = '0;
        core_col       = '0;
        res_ready      = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_ref[i*REF_BITS +: REF_BITS]    = ref_pat(i);
            req_read[i*READ_BITS +: READ_BITS] = read_pat(i);
        end

        #1;
        check("rst_req_ready", 256'(req_ready), 256'(0));
        check("rst_core_valid", 256'({core_valid, core_res_ready, res_valid, res_err}), 256'(0));
        check("rst_jobs_done", 256'(jobs_done), 256'(0));
        check("rst_core_ref", 256'(core_ref), 256'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // All requesters busy: strict rotation starting at 0
        for (int i = 0; i < N; i++) set_lens(i, 16, 16);
        req_valid = '1;
        for (int j = 0; j < 8; j++) begin
            wait_grant(ok);
            if (j == 7) req_valid = '0;
            check("rr_order", 256'(req_ready), 256'(1 << (j % 4)));
            v = '{id: j % 4, rlen: 16, dlen: 16, score: 100 + j, row: j, col: j + 1, err: 1'b0};
            complete(v, 0, lat);
        end
        req_valid = '0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Core not ready for 20 cycles: no issue until it rises
        core_ready = 1'b0;
        set_lens(1, 8, 8);
        req_valid = 4'b0010;
        wait_grant(ok);
        req_valid = '0;
        quiet = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (core_valid !== 1'b0) quiet = 1'b0;
        end
        check("core_valid_held_off", 256'(quiet), 256'(1));
        core_ready = 1'b1;
        v = '{id: 1, rlen: 8, dlen: 8, score: 1234, row: 3, col: 4, err: 1'b0};
        complete(v, 0, lat);
        check("core_ready_latency", 256'(lat), 256'(1));

        // Host stalls for 10 cycles while another request waits; then the
        // handshake and the pending request meet back to back
        set_lens(3, 4, 4);
        set_lens(0, 2, 3);
        req_valid = 4'b1000;
        wait_grant(ok);
        check("stall_grant", 256'(req_ready), 256'(4'b1000));
        req_valid = 4'b0001;
        v = '{id: 3, rlen: 4, dlen: 4, score: -300, row: 2, col: 1, err: 1'b0};
        complete(v, 10, lat);
        check("turnaround_no_grant", 256'(req_ready), 256'(0));
        @(negedge clk);
        check("turnaround_grant", 256'(req_ready), 256'(4'b0001));
        req_valid = '0;
        v = '{id: 0, rlen: 2, dlen: 3, score: 9, row: 1, col: 1, err: 1'b0};
        complete(v, 0, lat);

        // Reset while waiting on the core
        set_lens(2, 20, 20);
        req_valid = 4'b0100;
        wait_grant(ok);
        req_valid = '0;
        for (int k = 0; k < 10 && !core_valid; k++) @(negedge clk);
        @(negedge clk);
        check("wait_res_ready", 256'(core_res_ready), 256'(1));
        rst = 1'b1;
        #1;
        check("midjob_rst_ctrl", 256'({req_ready, core_valid, core_res_ready, res_valid, res_err}), 256'(0));
        check("midjob_rst_jobs", 256'(jobs_done), 256'(0));
        check("midjob_rst_res", 256'({res_id, res_score, res_row, res_col}), 256'(0));
        @(negedge clk);
        rst      = 1'b0;
        exp_jobs = 0;
        @(negedge clk);
        check("after_rst_no_res", 256'(res_valid), 256'(0));

        // Pointer was left at 3 before reset; reset returns priority to 0
        for (int i = 0; i < N; i++) set_lens(i, 16, 16);
        req_valid = '1;
        wait_grant(ok);
        req_valid = '0;
        check("rst_rr_ptr", 256'(req_ready), 256'(4'b0001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/sw_core_scheduler.md
# sw_core_scheduler

Round-robin scheduler that shares one `SW_core` Smith-Waterman datapath among `NUM_REQ` requesters. Accepts one ref/read job at a time, drives the core's valid/ready handshake, captures score/row/column and returns them tagged with the requester index. Sits between the host-side job sources and `SW_core`; one job is in flight at any time.

## Interface
- `NUM_REQ`, 4: number of requesters (2..16).
- `REF_MAX_LENGTH`, `` `REF_MAX_LENGTH ``: max reference bases, 2 bits/base.
- `READ_MAX_LENGTH`, `` `READ_MAX_LENGTH ``: max read bases.
- `SCORE_W`, `` `DP_SW_SCORE_BITWIDTH ``: signed score width.
- `TIMEOUT_CYCLES`, 65535: watchdog limit (used only with the watchdog feature).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester job present.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `req_ref`  in  NUM_REQ×2·REF_MAX_LENGTH  packed reference, MSB-aligned.
- `req_read`  in  NUM_REQ×2·READ_MAX_LENGTH  packed read, MSB-aligned.
- `req_ref_len`  in  NUM_REQ×(clog2(REF_MAX_LENGTH)+1)  1-based.
- `req_read_len`  in  NUM_REQ×(clog2(READ_MAX_LENGTH)+1)  1-based.
- `core_ready`  in  1  from `SW_core.o_ready`.
- `core_valid`  out  1  to `SW_core.i_valid`.
- `core_ref`, `core_read`, `core_ref_len`, `core_read_len`  out  core widths  to `SW_core`.
- `core_res_ready`  out  1  to `SW_core.i_ready`.
- `core_res_valid`  in  1  from `SW_core.o_valid`.
- `core_score`  in  SCORE_W; `core_row`  in  clog2(READ_MAX_LENGTH); `core_col`  in  clog2(REF_MAX_LENGTH).
- `res_valid`  out  1; `res_ready`  in  1.
- `res_id`  out  clog2(NUM_REQ); `res_score`, `res_row`, `res_col`  out  core widths; `res_err`  out  1.
- `jobs_done`  out  16  completed-job counter.

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE; IDLE → RESP directly on invalid job.
- IDLE: round-robin grant among `req_valid`, starting at `rr_ptr`; latch job and index; pulse `req_ready[g]`; `rr_ptr` ← g+1 (wrap to 0 at NUM_REQ).
- Invalid job: either length 0 or above max → no core issue; RESP with `res_err`=1, score/row/col 0.
- ISSUE: wait for `core_ready`; then drive `core_valid`=1 with job data for exactly one cycle; → WAIT.
- `core_ref`/`core_read`/lengths are zero whenever `core_valid`=0.
- WAIT: `core_res_ready`=1; on `core_res_valid`, capture score/row/col → RESP.
- RESP: hold `res_valid`=1 and all `res_*` stable until `res_ready`; on handshake increment `jobs_done` (wraps at 65535→0) → IDLE.
- `req_ready` never asserted outside IDLE; requests arriving meanwhile wait.

## Timing
- Reset values: all outputs 0, `rr_ptr`=0, state IDLE, `jobs_done`=0. Reset mid-job abandons it silently; no result is emitted.
- Grant: `req_valid` sampled at edge T → `req_ready` high during cycle T+1, state ISSUE.
- Issue: `core_ready` sampled high at edge E in ISSUE → `core_valid` high in cycle E+1 only.
- Result: `core_res_valid` sampled at edge R → `res_valid` high from cycle R+1.
- Invalid job: `res_valid` high 2 cycles after grant.
- Minimum turnaround: `res_ready` handshake at edge H → next grant can be sampled at edge H+1.
- `res_ready` and a new `req_valid` in the same cycle: the result completes first; the new grant follows one cycle later.

## Configuration
- `SW_SCHED_WATCHDOG_EN` defined: a counter runs in ISSUE+WAIT. When it reaches `TIMEOUT_CYCLES`, drop `core_res_ready`, go to RESP with `res_err`=1 and score/row/col 0.
- Not defined: no counter; WAIT lasts indefinitely.

## Structure
- Shared package `sw_pkg`: FSM state enum, job struct (ref, read, lengths), result struct (id, score, row, col, err).
- One sub-module `sw_rr_arbiter`: combinational one-hot round-robin grant from request vector and pointer.

## Test plan
- Single job, requester 2, ref_len=128, read_len=128 → one `core_valid` pulse, `res_id`=2, result equals the core output, `jobs_done`=1.
- All 4 `req_valid` held high for 8 jobs → grant order 0,1,2,3,0,1,2,3.
- read_len=0 on requester 1 → `core_valid` never asserted; `res_err`=1 with `res_id`=1 two cycles after grant.
- `core_ready` low for 20 cycles → `core_valid` stays 0; it pulses once the cycle after `core_ready` rises.
- `res_ready` low for 10 cycles → `res_*` stable, no new `req_ready`; `rst` asserted in WAIT → all outputs 0 immediately.
- Watchdog build, `TIMEOUT_CYCLES`=100, core never responds → `res_err`=1 after 100 cycles.
